credit_tx: RTL and testbench
============================

// Module: credit_tx
// PURPOSE
//   Credit-based link transmitter: the sending end of a registered-ready link.
//   Takes a valid/ready upstream stream and emits one-cycle data pulses downstream, with no downstream ready.
//   A sent beat consumes one credit. The receiver returns each credit with a one-cycle credit_ret_i pulse.
//   Sits ahead of long or registered interconnect paths where a combinational ready cannot reach the producer.
// PARAMETERS
//   DATA_WIDTH   8   payload width in bits
//   CREDIT_INIT  4   receiver buffer depth = credits held after reset (1..2^CNT_WIDTH-1)
//   CNT_WIDTH    3   credit counter width; must hold CREDIT_INIT
// PORTS
//   clk            in   1           clock, rising edge
//   rst_n          in   1           asynchronous active-low reset
//   bwd_data_i     in   DATA_WIDTH  upstream payload
//   bwd_valid_i    in   1           upstream valid
//   bwd_ready_o    out  1           upstream ready
//   fwd_data_o     out  DATA_WIDTH  link payload, registered
//   fwd_valid_o    out  1           link valid pulse, registered; the receiver must accept it
//   credit_ret_i   in   1           one credit returned per cycle high
//   flush_i        in   1           request drain: stop sending, wait until all credits are back
//   flush_done_o   out  1           one-cycle pulse when the drain completes
//   credit_cnt_o   out  CNT_WIDTH   credits currently held
//   err_o          out  1           sticky credit-overflow error (see CONFIGURATION)
// BEHAVIOUR
//   Reset values: fwd_valid_o=0, bwd_ready_o=0, flush_done_o=0, err_o=0, credit_cnt_o=CREDIT_INIT.
//   fwd_data_o is not reset.
//   FSM states: INIT, RUN, FLUSH.
//   - INIT: held for exactly one cycle after reset is released, then moves to RUN.
//     bwd_ready_o=0 during INIT.
//   - RUN: bwd_ready_o = (credit_cnt != 0). Combinational from registered state only.
//     flush_i=1 moves to FLUSH on the next edge. A handshake in the same cycle still completes.
//   - FLUSH: bwd_ready_o=0. The FSM waits for credit_cnt==CREDIT_INIT.
//     When that holds, it pulses flush_done_o for one cycle and returns to RUN.
//     If credits are already full on entry, the pulse comes one cycle after entry.
//   Handshake: hs = bwd_valid_i & bwd_ready_o.
//   - On hs: fwd_data_o <= bwd_data_i and fwd_valid_o <= 1 at the next edge. Latency is 1 cycle.
//   - Without hs: fwd_valid_o <= 0.
//   - Back-to-back beats run at one per cycle while credits remain.
//   Credit counter update per cycle:
//   - hs & !ret: cnt-1
//   - !hs & ret: cnt+1
//   - hs & ret: unchanged
//   - neither: unchanged
//   Boundaries:
//   - cnt==0: ready=0 and no beat is sent. A ret in that cycle makes ready=1 in the next cycle.
//   - cnt==1 with hs: cnt becomes 0 and ready drops in the next cycle.
//   - Overflow (ret while cnt==CREDIT_INIT and no hs): cnt saturates at CREDIT_INIT and does not wrap.
//   - Reset mid-operation: all state returns to reset values immediately.
//     Any beats in flight are lost. The receiver must be reset together with this block.
// CONFIGURATION
//   Macro CREDIT_TX_ERR_EN.
//   - Defined: err_o sets on the first overflow and stays set until reset.
//   - Defined: simulation-only assertions also fire on overflow and on hs with cnt==0.
//   - Undefined: err_o is tied 0 and no detection logic is built.
//   - The counter saturation behaviour is the same in both cases.
// STRUCTURE
//   Shared package/header: FSM state encodings (INIT/RUN/FLUSH, 2 bits) and the credit-counter update-select encoding.
//   Sub-module credit_counter:
//   - Saturating up/down counter with load value CREDIT_INIT.
//   - Outputs: zero, full and overflow flags.
//   - The top level holds the FSM, the output registers and the error flag.
// TESTING
//   1. Reset release with bwd_valid_i=1 held:
//      - no beat during INIT;
//      - beats on 4 consecutive cycles;
//      - credit_cnt_o reaches 0 and ready goes low;
//      - then nothing more is sent.
//   2. CREDIT_INIT=4, data 0x11..0x55 offered, one credit_ret_i per cycle starting at the third beat:
//      - beats at one per cycle, with the cycle after each hs carrying the matching payload;
//      - 0x55 is sent without a stall.
//   3. hs and credit_ret_i in the same cycle with cnt=2 -> cnt stays 2 and the beat appears on the next cycle.
//   4. flush_i with 3 credits outstanding, returned at cycles +2, +5 and +6:
//      - ready=0 throughout FLUSH;
//      - flush_done_o pulses exactly once, one cycle after cnt reaches 4;
//      - then RUN resumes.
//   5. Extra credit_ret_i at cnt=4:
//      - cnt stays 4;
//      - err_o=1 and stays 1 if CREDIT_TX_ERR_EN is defined, else err_o=0.
//   6. rst_n asserted mid-burst with cnt=1:
//      - outputs go to reset values asynchronously;
//      - cnt=4 after release;
//      - one INIT cycle precedes the next beat.

Source files
------------

// File: rtl/credit_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : credit_tx_pkg
//  Brief    : Shared encodings for the credit-based link transmitter:
//             FSM state codes and the credit-counter update select.
//  Revision : 1.0 - initial release
// ============================================================================
package credit_tx_pkg;

    // Transmitter control states
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Credit counter update select
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_sel_t;

    // A beat spends a credit, a return gives one back; both together cancel.
    function automatic cnt_sel_t cnt_select(input logic hs, input logic ret);
        cnt_sel_t sel;
        case ({hs, ret})
            2'b10:   sel = CNT_DEC;
            2'b01:   sel = CNT_INC;
            default: sel = CNT_HOLD;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/credit_tx_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : credit_counter
//  Brief    : Saturating up/down credit counter loaded with CREDIT_INIT on
//             reset. Reports empty, full and overflow (increment while full).
//  Revision : 1.0 - initial release
// ============================================================================
module credit_counter
    import credit_tx_pkg::*;
#(
    parameter int CREDIT_INIT = 4,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  cnt_sel_t             sel,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 zero,
    output logic                 full,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] C_LOAD = CNT_WIDTH'(CREDIT_INIT);
    localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Count up on return, down on send; clamp at both ends instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= C_LOAD;
        end else begin
            case (sel)
                CNT_INC: if (r_cnt != C_LOAD)     r_cnt <= r_cnt + C_ONE;
                CNT_DEC: if (r_cnt != '0)         r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);
    assign full = (r_cnt == C_LOAD);
    assign ovf  = (sel == CNT_INC) && full;

endmodule
`default_nettype wire

// File: rtl/credit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : credit_tx
//  Brief    : Credit-based link transmitter. Converts a valid/ready upstream
//             stream into registered one-cycle data pulses, spending one
//             credit per beat; credits come back via credit_ret_i. A flush
//             request stops sending until every credit has returned.
//             Optional macro CREDIT_TX_ERR_EN builds the sticky overflow
//             error flag and simulation assertions.
//  Revision : 1.0 - initial release
// ============================================================================
module credit_tx
    import credit_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CREDIT_INIT = 4,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] bwd_data_i,
    input  logic                  bwd_valid_i,
    output logic                  bwd_ready_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  fwd_valid_o,
    input  logic                  credit_ret_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [CNT_WIDTH-1:0]  credit_cnt_o,
    output logic                  err_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_flush_done_nxt;
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_zero;
    logic                  w_full;
    logic                  w_ovf;
    cnt_sel_t              w_cnt_sel;
    logic                  r_fwd_valid;
    logic                  r_flush_done;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    assign w_hs      = bwd_valid_i & w_ready;
    assign w_cnt_sel = cnt_select(w_hs, credit_ret_i);

    credit_counter #(
        .CREDIT_INIT (CREDIT_INIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_credit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (w_cnt_sel),
        .cnt   (credit_cnt_o),
        .zero  (w_zero),
        .full  (w_full),
        .ovf   (w_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state, ready and flush-completion; ready depends on registered state only
    always_comb begin
        w_state_nxt      = r_state;
        w_ready          = 1'b0;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ready = !w_zero;
                if (flush_i) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_full) begin
                    w_flush_done_nxt = 1'b1;
                    w_state_nxt      = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Link valid and flush-done pulses, one cycle after their cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_valid  <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_fwd_valid  <= w_hs;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    // Payload register; only meaningful while fwd_valid_o is high, so no reset
    always_ff @(posedge clk) begin
        if (w_hs) r_fwd_data <= bwd_data_i;
    end

    assign bwd_ready_o  = w_ready;
    assign fwd_valid_o  = r_fwd_valid;
    assign fwd_data_o   = r_fwd_data;
    assign flush_done_o = r_flush_done;

`ifdef CREDIT_TX_ERR_EN
    logic r_err;

    // Sticky overflow flag: a credit came back that was never spent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_err <= 1'b0;
        else if (w_ovf) r_err <= 1'b1;
    end

    assign err_o = r_err;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !w_ovf);
    a_no_send_empty: assert property (@(posedge clk) disable iff (!rst_n) !(w_hs && w_zero));
`endif
`else
    logic w_unused;
    assign w_unused = w_ovf;
    assign err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_credit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_credit_tx
//  Brief    : Self-checking bench for credit_tx (DATA_WIDTH=8, CREDIT_INIT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_credit_tx;

`ifdef CREDIT_TX_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] bwd_data_i;
    logic       bwd_valid_i;
    logic       bwd_ready_o;
    logic [7:0] fwd_data_o;
    logic       fwd_valid_o;
    logic       credit_ret_i;
    logic       flush_i;
    logic       flush_done_o;
    logic [2:0] credit_cnt_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;

    credit_tx #(
        .DATA_WIDTH  (8),
        .CREDIT_INIT (4),
        .CNT_WIDTH   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bwd_data_i   (bwd_data_i),
        .bwd_valid_i  (bwd_valid_i),
        .bwd_ready_o  (bwd_ready_o),
        .fwd_data_o   (fwd_data_o),
        .fwd_valid_o  (fwd_valid_o),
        .credit_ret_i (credit_ret_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .credit_cnt_o (credit_cnt_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ret;
        logic       fl;
        logic       e_rdy;
        logic       e_fv;
        logic [7:0] e_d;
        logic [2:0] e_cnt;
        logic       e_fd;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic ret,
                                input logic fl, input logic e_rdy, input logic e_fv,
                                input logic [7:0] e_d, input logic [2:0] e_cnt,
                                input logic e_fd, input logic e_err);
        vec_t r;
        r.v = v; r.d = d; r.ret = ret; r.fl = fl;
        r.e_rdy = e_rdy; r.e_fv = e_fv; r.e_d = e_d; r.e_cnt = e_cnt;
        r.e_fd = e_fd; r.e_err = e_err;
        vq.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic fv,
                              input logic [7:0] d, input logic [2:0] cnt,
                              input logic fd, input logic err);
        check({tag, ".ready"},      {31'd0, bwd_ready_o},  {31'd0, rdy});
        check({tag, ".fwd_valid"},  {31'd0, fwd_valid_o},  {31'd0, fv});
        if (fv) check({tag, ".fwd_data"}, {24'd0, fwd_data_o}, {24'd0, d});
        check({tag, ".credit_cnt"}, {29'd0, credit_cnt_o}, {29'd0, cnt});
        check({tag, ".flush_done"}, {31'd0, flush_done_o}, {31'd0, fd});
        check({tag, ".err"},        {31'd0, err_o},        {31'd0, err});
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ret, input logic fl);
        bwd_valid_i  = v;
        bwd_data_i   = d;
        credit_ret_i = ret;
        flush_i      = fl;
    endtask

    // Each row: at the falling edge check current outputs, then drive inputs
    task automatic run_queue(input string name);
        foreach (vq[i]) begin
            @(negedge clk);
            check_outs($sformatf("%s[%0d]", name, i), vq[i].e_rdy, vq[i].e_fv,
                       vq[i].e_d, vq[i].e_cnt, vq[i].e_fd, vq[i].e_err);
            drive(vq[i].v, vq[i].d, vq[i].ret, vq[i].fl);
        end
        vq.delete();
    endtask

    // Reset, check reset values, release on a falling edge (DUT then sits in INIT)
    task automatic do_reset(input logic hold_v);
        @(negedge clk);
        rst_n = 1'b0;
        drive(hold_v, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // 1: valid held through reset release; drain all credits; ret at cnt 0
        do_reset(1'b1);
        add(1, 8'hA1, 0, 0,  1, 0, 8'h00, 3'd4, 0, 0);
        add(1, 8'hA2, 0, 0,  1, 1, 8'hA1, 3'd3, 0, 0);
        add(1, 8'hA3, 0, 0,  1, 1, 8'hA2, 3'd2, 0, 0);
        add(1, 8'hA4, 0, 0,  1, 1, 8'hA3, 3'd1, 0, 0);
        add(1, 8'hA5, 0, 0,  0, 1, 8'hA4, 3'd0, 0, 0);
        add(1, 8'hA5, 0, 0,  0, 0, 8'h00, 3'd0, 0, 0);
        add(0, 8'h00, 1, 0,  0, 0, 8'h00, 3'd0, 0, 0);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd1, 0, 0);
        run_queue("drain");

        // 2-4: streaming with returns, hs+ret at cnt 2, flush with 3 outstanding
        do_reset(1'b0);
        add(1, 8'h11, 0, 0,  1, 0, 8'h00, 3'd4, 0, 0);
        add(1, 8'h22, 0, 0,  1, 1, 8'h11, 3'd3, 0, 0);
        add(1, 8'h33, 1, 0,  1, 1, 8'h22, 3'd2, 0, 0);
        add(1, 8'h44, 1, 0,  1, 1, 8'h33, 3'd2, 0, 0);
        add(1, 8'h55, 1, 0,  1, 1, 8'h44, 3'd2, 0, 0);
        add(0, 8'h00, 1, 0,  1, 1, 8'h55, 3'd2, 0, 0);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd3, 0, 0);
        add(1, 8'h66, 0, 0,  1, 0, 8'h00, 3'd3, 0, 0);
        add(1, 8'h77, 1, 0,  1, 1, 8'h66, 3'd2, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h77, 3'd2, 0, 0);
        add(1, 8'h88, 0, 1,  1, 0, 8'h00, 3'd2, 0, 0); // flush with same-cycle hs
        add(1, 8'h99, 0, 0,  0, 1, 8'h88, 3'd1, 0, 0); // c1
        add(1, 8'h99, 1, 0,  0, 0, 8'h00, 3'd1, 0, 0); // c2 return
        add(1, 8'h99, 0, 0,  0, 0, 8'h00, 3'd2, 0, 0); // c3
        add(1, 8'h99, 0, 0,  0, 0, 8'h00, 3'd2, 0, 0); // c4
        add(1, 8'h99, 1, 0,  0, 0, 8'h00, 3'd2, 0, 0); // c5 return
        add(1, 8'h99, 1, 0,  0, 0, 8'h00, 3'd3, 0, 0); // c6 return
        add(0, 8'h00, 0, 0,  0, 0, 8'h00, 3'd4, 0, 0); // c7 full
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd4, 1, 0); // c8 done pulse, RUN
        add(1, 8'hAB, 0, 0,  1, 0, 8'h00, 3'd4, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'hAB, 3'd3, 0, 0);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd3, 0, 0);
        run_queue("stream_flush");

        // 5: extra credit return at full count
        do_reset(1'b0);
        add(0, 8'h00, 1, 0,  1, 0, 8'h00, 3'd4, 0, 0);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd4, 0, EXP_ERR);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 3'd4, 0, EXP_ERR);
        run_queue("overflow");

        // 6: asynchronous reset mid-burst at cnt 1
        do_reset(1'b0);
        add(1, 8'hC1, 0, 0,  1, 0, 8'h00, 3'd4, 0, 0);
        add(1, 8'hC2, 0, 0,  1, 1, 8'hC1, 3'd3, 0, 0);
        add(1, 8'hC3, 0, 0,  1, 1, 8'hC2, 3'd2, 0, 0);
        add(1, 8'hC4, 0, 0,  1, 1, 8'hC3, 3'd1, 0, 0);
        run_queue("burst");
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_outs("init", 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("after_init", 1'b1, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("first_beat", 1'b1, 1'b1, 8'hC4, 3'd3, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("idle", 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
